ultrasonic_scheduler: RTL and testbench
=======================================

# ultrasonic_scheduler

Measurement sequencer for the HC-SR04-style ultrasonic sensor in the tamagotchi's proximity path. The block issues trigger pulses, times the echo in microsecond ticks, and aborts measurements that have no echo. It enforces the sensor's inter-measurement holdoff and publishes a distance sample with a hysteretic "near" flag for the game logic. It runs free when enabled, or performs single shots on request.

## Interface
- `TICK_DIV`, 50: clk cycles per 1 µs tick (50 MHz clk).
- `TRIG_TICKS`, 10: trigger pulse width in ticks.
- `TIMEOUT_TICKS`, 30000: maximum ticks from trigger end to echo fall.
- `HOLDOFF_TICKS`, 60000: quiet time after each measurement.
- `NEAR_LO`, 100: `near_o` clears below this distance.
- `NEAR_HI`, 200: `near_o` sets above this distance.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable_i` in 1: continuous measurement mode.
- `start_i` in 1: single-shot request; sampled only in IDLE.
- `echo_i` in 1: raw sensor echo; asynchronous to `clk`.
- `trigger_o` out 1: sensor trigger.
- `busy_o` out 1: high in any state other than IDLE.
- `dist_o` out 16: last valid echo width in ticks.
- `dist_valid_o` out 1: one-cycle pulse when `dist_o` updates.
- `timeout_o` out 1: one-cycle pulse on an aborted measurement.
- `near_o` out 1: hysteretic proximity flag.

## Operation
- `echo_i` passes through a 2-flop synchronizer. Rise and fall detection use the synchronized value.
- The tick prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at wrap. It free-runs and is cleared by reset only.
- States and transitions:
  - IDLE → TRIG when `enable_i` or `start_i` is high.
  - TRIG: `trigger_o`=1 for TRIG_TICKS ticks, then → WAIT_RISE. The tick counter clears on entry.
  - WAIT_RISE: on echo rise → MEASURE, with the echo counter cleared to 0.
  - MEASURE: the echo counter increments on each tick while echo is high. The counter saturates at 16'hFFFF. On echo fall → HOLDOFF and latch the sample.
  - Timeout: in WAIT_RISE or MEASURE, when the shared tick counter (cleared at TRIG exit) reaches TIMEOUT_TICKS → HOLDOFF. `timeout_o` pulses. `dist_o` is unchanged and `near_o` is forced to 0.
  - HOLDOFF: wait HOLDOFF_TICKS ticks, then → TRIG if `enable_i`=1, else → IDLE.
- `start_i` is ignored outside IDLE. No request queueing.
- Deasserting `enable_i` mid-measurement does not abort it. The current cycle completes through HOLDOFF.
- Sample latch:
  - `dist_o` <= echo count (or the filtered value, see Configuration).
  - `dist_valid_o` pulses.
- `near_o` update on each valid sample:
  - `dist_o` < NEAR_LO → 0.
  - `dist_o` > NEAR_HI → 1.
  - Otherwise hold.
- Echo fall and timeout in the same cycle: the fall wins. The sample is valid and no `timeout_o`.
- Echo already high on WAIT_RISE entry: not a rise. Wait for a low-then-high transition, or timeout.

## Timing
- Reset values: state IDLE, `trigger_o`=0, `busy_o`=0, `dist_o`=0, `dist_valid_o`=0, `timeout_o`=0, `near_o`=0, all counters 0.
- Echo latency: 2 cycles of synchronizer, plus 1 cycle of edge detect.
- `dist_valid_o` asserts 1 cycle after the fall is detected.
- `trigger_o` asserts the cycle after the state leaves IDLE. Width is TRIG_TICKS ticks (±1 tick of prescaler phase).
- Async reset mid-measurement:
  - `trigger_o` drops immediately and all outputs take their reset values.
  - No holdoff is enforced after reset.

## Configuration
- `ULTRASONIC_AVG_EN` defined:
  - `dist_o` is the mean of the last 4 valid samples: an 18-bit sum, shifted right by 2.
  - The first valid sample after reset preloads all 4 history slots.
  - Timeouts do not enter the history.
  - `dist_valid_o` is delayed 1 extra cycle.
  - `near_o` uses the averaged value.
- Undefined: `dist_o` is the raw sample. No history registers.

## Structure
- Package `ultrasonic_pkg`:
  - State enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF).
  - Default timing constants.
  - `DIST_W`=16.
- One sub-module, `us_tick_gen`: parameterized prescaler emitting the 1 µs tick.
- The synchronizer, FSM, counters, averaging and hysteresis live in the top.

## Test plan
Bench parameters: TICK_DIV=2, TRIG_TICKS=10, TIMEOUT_TICKS=400, HOLDOFF_TICKS=50.
- Single shot: `start_i` pulse, echo high for 150 ticks → one `trigger_o` pulse of 10 ticks; `dist_o`=150; one `dist_valid_o`; `near_o`=0 (within hysteresis band); return to IDLE after 50 ticks.
- Hysteresis: continuous mode, echoes of 250, 150, 90, 150 ticks → `near_o` sequence 1, 1, 0, 0.
- Timeout: no echo → `timeout_o` pulses 400 ticks after trigger end; `dist_o` holds its prior value; `near_o`=0; the next trigger follows after holdoff.
- Fall coincident with the timeout tick → `dist_valid_o`=1, `timeout_o`=0.
- Reset asserted mid-MEASURE → all outputs are at reset values before the next clock edge; a fresh `start_i` works normally.
- With `ULTRASONIC_AVG_EN`: samples 100, 200, 200, 200 → `dist_o` sequence 100, 125, 150, 175.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic measurement sequencer.
// Provides the FSM state enum, counter widths and default tick constants.
package ultrasonic_pkg;

   localparam int DIST_W = 16;
   localparam int CNT_W  = 16;

   localparam int TICK_DIV_DEF      = 50;
   localparam int TRIG_TICKS_DEF    = 10;
   localparam int TIMEOUT_TICKS_DEF = 30000;
   localparam int HOLDOFF_TICKS_DEF = 60000;
   localparam int NEAR_LO_DEF       = 100;
   localparam int NEAR_HI_DEF       = 200;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_e;

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1, tick_o high in the wrap cycle.
// Ports: clk, rst (async, active high), tick_o (one-cycle tick).
module us_tick_gen #(
   parameter int TICK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ultrasonic_scheduler.sv
// HC-SR04 measurement sequencer: trigger, echo timing, timeout, holdoff and
// hysteretic near flag. Define ULTRASONIC_AVG_EN for a 4-sample mean on dist_o.
// Ports: clk, rst (async, active high); enable_i continuous mode; start_i single
// shot (IDLE only); echo_i raw echo; trigger_o; busy_o; dist_o; dist_valid_o;
// timeout_o; near_o.
module ultrasonic_scheduler
   import ultrasonic_pkg::*;
#(
   parameter int TICK_DIV      = TICK_DIV_DEF,
   parameter int TRIG_TICKS    = TRIG_TICKS_DEF,
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
   parameter int HOLDOFF_TICKS = HOLDOFF_TICKS_DEF,
   parameter int NEAR_LO       = NEAR_LO_DEF,
   parameter int NEAR_HI       = NEAR_HI_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   input  logic              start_i,
   input  logic              echo_i,
   output logic              trigger_o,
   output logic              busy_o,
   output logic [DIST_W-1:0] dist_o,
   output logic              dist_valid_o,
   output logic              timeout_o,
   output logic              near_o
);

   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_TICKS - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF_TICKS - 1);
   localparam logic [DIST_W-1:0] N_LO     = DIST_W'(NEAR_LO);
   localparam logic [DIST_W-1:0] N_HI     = DIST_W'(NEAR_HI);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;
   logic [DIST_W-1:0] ecnt_q, ecnt_d;
   logic              echo_s1_q, echo_s2_q, echo_p_q;
   logic [DIST_W-1:0] dist_q, dist_d;
   logic              valid_q, near_q, near_d, to_q;
   logic              samp_d, to_d;
   logic              tick, rise, fall, tmo;
   logic [DIST_W-1:0] new_val;
   logic              load;

   us_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   assign rise = echo_s2_q & ~echo_p_q;
   assign fall = ~echo_s2_q & echo_p_q;
   assign tmo  = tick && (tcnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      ecnt_d  = ecnt_q;
      samp_d  = 1'b0;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable_i || start_i) begin
               state_d = TRIG;
               tcnt_d  = '0;
            end
         end
         TRIG: begin
            if (tick) begin
               if (tcnt_q == TRIG_LAST) begin
                  state_d = WAIT_RISE;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         WAIT_RISE: begin
            if (tick) tcnt_d = tcnt_q + 1'b1;
            if (tmo) begin
               state_d = HOLDOFF;
               tcnt_d  = '0;
               to_d    = 1'b1;
            end else if (rise) begin
               // The rise cycle is already echo-high, so its tick counts.
               state_d = MEASURE;
               ecnt_d  = DIST_W'(tick);
            end
         end
         MEASURE: begin
            if (tick) tcnt_d = tcnt_q + 1'b1;
            if (tick && echo_s2_q && (ecnt_q != '1))
               ecnt_d = ecnt_q + 1'b1;
            // A fall on the timeout tick still yields a valid sample.
            if (fall) begin
               state_d = HOLDOFF;
               tcnt_d  = '0;
               samp_d  = 1'b1;
            end else if (tmo) begin
               state_d = HOLDOFF;
               tcnt_d  = '0;
               to_d    = 1'b1;
            end
         end
         HOLDOFF: begin
            if (tick) begin
               if (tcnt_q == HO_LAST) begin
                  state_d = enable_i ? TRIG : IDLE;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ULTRASONIC_AVG_EN
   localparam int SUM_W = DIST_W + 2;

   logic [DIST_W-1:0] hist_q [4];
   logic              have_q, pend_q;
   logic [SUM_W-1:0]  sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < 4; i++) sum = sum + SUM_W'(hist_q[i]);
      new_val = sum[SUM_W-1:2];
      load    = pend_q;
   end

   // First sample after reset fills every slot so the mean starts at it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
         have_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         pend_q <= samp_d;
         if (samp_d) begin
            have_q    <= 1'b1;
            hist_q[0] <= ecnt_q;
            for (int i = 1; i < 4; i++)
               hist_q[i] <= have_q ? hist_q[i-1] : ecnt_q;
         end
      end
   end
`else
   always_comb begin
      new_val = ecnt_q;
      load    = samp_d;
   end
`endif

   always_comb begin
      dist_d = load ? new_val : dist_q;
      near_d = near_q;
      if (load) begin
         if (new_val < N_LO)      near_d = 1'b0;
         else if (new_val > N_HI) near_d = 1'b1;
      end
      if (to_d) near_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tcnt_q    <= '0;
         ecnt_q    <= '0;
         echo_s1_q <= 1'b0;
         echo_s2_q <= 1'b0;
         echo_p_q  <= 1'b0;
         dist_q    <= '0;
         valid_q   <= 1'b0;
         to_q      <= 1'b0;
         near_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         ecnt_q    <= ecnt_d;
         echo_s1_q <= echo_i;
         echo_s2_q <= echo_s1_q;
         echo_p_q  <= echo_s2_q;
         dist_q    <= dist_d;
         valid_q   <= load;
         to_q      <= to_d;
         near_q    <= near_d;
      end
   end

   assign trigger_o    = (state_q == TRIG);
   assign busy_o       = (state_q != IDLE);
   assign dist_o       = dist_q;
   assign dist_valid_o = valid_q;
   assign timeout_o    = to_q;
   assign near_o       = near_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Self-checking bench for ultrasonic_scheduler: a tick-level model of echo
// widths, averaging and hysteresis, plus directed literal expectations.
module tb_ultrasonic_scheduler;

   localparam int TD  = 2;
   localparam int TT  = 10;
   localparam int TO  = 400;
   localparam int HO  = 50;
   localparam int NLO = 100;
   localparam int NHI = 200;
`ifdef ULTRASONIC_AVG_EN
   localparam int AVG_LAT = 1;
`else
   localparam int AVG_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst, enable_i, start_i, echo_i;
   logic        trigger_o, busy_o, dist_valid_o, timeout_o, near_o;
   logic [15:0] dist_o;

   always #5 clk = ~clk;

   ultrasonic_scheduler #(
      .TICK_DIV      (TD),
      .TRIG_TICKS    (TT),
      .TIMEOUT_TICKS (TO),
      .HOLDOFF_TICKS (HO),
      .NEAR_LO       (NLO),
      .NEAR_HI       (NHI)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .start_i      (start_i),
      .echo_i       (echo_i),
      .trigger_o    (trigger_o),
      .busy_o       (busy_o),
      .dist_o       (dist_o),
      .dist_valid_o (dist_valid_o),
      .timeout_o    (timeout_o),
      .near_o       (near_o)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Model: echo widths in ticks measured on echo_i, sample mean, hysteresis.
   int wq[$];
   int hist[4];
   bit have;
   int ecnt_m, m_dist, raw, val, tw;
   bit m_near;
   int n_valid = 0;
   int n_to = 0;
   int n_trig = 0;

   always @(negedge clk) begin
      if (rst) begin
         wq.delete();
         have = 0;
         ecnt_m = 0;
         m_dist = 0;
         m_near = 0;
         tw = 0;
      end else begin
         if (echo_i) ecnt_m++;
         else if (ecnt_m > 0) begin
            wq.push_back(ecnt_m / TD);
            ecnt_m = 0;
         end
         if (dist_valid_o === 1'b1) begin
            n_valid++;
            if (wq.size() == 0) check("valid_unexpected", 1, 0);
            else begin
               raw = wq.pop_front();
`ifdef ULTRASONIC_AVG_EN
               if (!have) for (int i = 0; i < 4; i++) hist[i] = raw;
               else begin
                  for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                  hist[0] = raw;
               end
               have = 1;
               val = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
               val = raw;
`endif
               m_dist = val;
               if (val < NLO) m_near = 0;
               else if (val > NHI) m_near = 1;
            end
         end
         if (timeout_o === 1'b1) begin
            n_to++;
            m_near = 0;
         end
         check("dist_o", dist_o, m_dist);
         check("near_o", near_o, m_near);
         if (trigger_o === 1'b1) begin
            tw++;
            check("busy_in_trig", busy_o, 1);
         end else if (tw > 0) begin
            check("trig_width", (tw >= 2*TT-1 && tw <= 2*TT), 1);
            n_trig++;
            tw = 0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_trig_fall(input string nm);
      int k = 0;
      while (trigger_o !== 1'b1 && k < 3000) begin step(); k++; end
      while (trigger_o !== 1'b0 && k < 3000) begin step(); k++; end
      if (k >= 3000) check({nm, "_trig_bound"}, 0, 1);
   endtask

   task automatic wait_valid(input string nm);
      int k = 0;
      while (dist_valid_o !== 1'b1 && k < 3000) begin step(); k++; end
      if (k >= 3000) check({nm, "_valid_bound"}, 0, 1);
   endtask

   task automatic wait_idle(input string nm, output int k);
      k = 0;
      while (busy_o !== 1'b0 && k < 3000) begin step(); k++; end
      if (k >= 3000) check({nm, "_idle_bound"}, 0, 1);
   endtask

   task automatic echo_pulse(input int start, input int len);
      repeat (start) step();
      echo_i = 1'b1;
      repeat (len) step();
      echo_i = 1'b0;
   endtask

   int k, v0, t0, g0;
   int hw[4]   = '{250, 150, 90, 150};
   bit hn[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
   int as_in[4] = '{100, 200, 200, 200};
`ifdef ULTRASONIC_AVG_EN
   int as_ex[4] = '{100, 125, 150, 175};
`else
   int as_ex[4] = '{100, 200, 200, 200};
`endif

   initial begin
      rst = 1'b1;
      enable_i = 1'b0;
      start_i = 1'b0;
      echo_i = 1'b0;
      repeat (3) step();
      check("rst_trigger", trigger_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_dist", dist_o, 0);
      check("rst_valid", dist_valid_o, 0);
      check("rst_timeout", timeout_o, 0);
      check("rst_near", near_o, 0);
      rst = 1'b0;
      step();

      // Single shot, 150 ticks.
      v0 = n_valid; g0 = n_trig;
      pulse_start();
      wait_trig_fall("ss");
      echo_pulse(20, 2*150);
      wait_valid("ss");
      check("ss_dist", dist_o, 150);
      check("ss_near", near_o, 0);
      wait_idle("ss", k);
      check("ss_idle_lat", (k >= 2*HO-1-AVG_LAT && k <= 2*HO-AVG_LAT), 1);
      check("ss_valid_cnt", n_valid - v0, 1);
      check("ss_trig_cnt", n_trig - g0, 1);

      // Continuous mode hysteresis; enable dropped during the last one.
      g0 = n_trig;
      enable_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_trig_fall("hy");
         if (i == 3) enable_i = 1'b0;
         echo_pulse(20, 2*hw[i]);
         wait_valid("hy");
`ifndef ULTRASONIC_AVG_EN
         check("hy_near", near_o, hn[i]);
         check("hy_dist", dist_o, hw[i]);
`endif
      end
      wait_idle("hy", k);
      check("hy_trig_cnt", n_trig - g0, 4);

      // Far sample, then no-echo timeout in continuous mode.
      pulse_start();
      wait_trig_fall("far");
      echo_pulse(20, 2*250);
      wait_valid("far");
      wait_idle("far", k);
      enable_i = 1'b1;
      t0 = n_to;
      wait_trig_fall("to");
      k = 0;
      while (timeout_o !== 1'b1 && k < 2000) begin step(); k++; end
      check("to_latency", k, 2*TO);
      check("to_near", near_o, 0);
`ifndef ULTRASONIC_AVG_EN
      check("to_dist_hold", dist_o, 250);
`endif
      k = 0;
      while (trigger_o !== 1'b1 && k < 500) begin step(); k++; end
      check("to_holdoff", k, 2*HO);
      check("to_count", n_to - t0, 1);

      // Fall on the same tick as the timeout: sample wins.
      enable_i = 1'b0;
      v0 = n_valid; t0 = n_to;
      wait_trig_fall("co");
      echo_pulse(11, 786);
      wait_valid("co");
`ifndef ULTRASONIC_AVG_EN
      check("co_dist", dist_o, 393);
`endif
      wait_idle("co", k);
      check("co_valid", n_valid - v0, 1);
      check("co_no_timeout", n_to - t0, 0);

      // Async reset in MEASURE, then a fresh shot.
      pulse_start();
      wait_trig_fall("ra");
      echo_pulse(20, 100);
      #1 rst = 1'b1;
      #1;
      check("ra_trigger", trigger_o, 0);
      check("ra_busy", busy_o, 0);
      check("ra_dist", dist_o, 0);
      check("ra_valid", dist_valid_o, 0);
      check("ra_timeout", timeout_o, 0);
      check("ra_near", near_o, 0);
      echo_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      pulse_start();
      check("ra_restart_trig", trigger_o, 1);
      wait_trig_fall("ra2");
      echo_pulse(20, 2*150);
      wait_valid("ra2");
      check("ra2_dist", dist_o, 150);
      check("ra2_near", near_o, 0);
      wait_idle("ra2", k);

      // Sample sequence from a clean history.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         pulse_start();
         wait_trig_fall("av");
         echo_pulse(20, 2*as_in[i]);
         wait_valid("av");
         check("av_dist", dist_o, as_ex[i]);
         wait_idle("av", k);
      end
      check("av_queue_empty", wq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
